// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper sequencer.
// Holds the FSM state type, coil width and full-step phase table.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int COIL_W = 4;

    // Coil order {A, B, A', B'}; entry 0 is the lowest slice.
    localparam logic [3:0][COIL_W-1:0] PHASE = {
        4'b1001,
        4'b0011,
        4'b0110,
        4'b1100
    };

    function automatic logic [COIL_W-1:0] phase_of(
        input logic [1:0] idx
    );
        return PHASE[idx];
    endfunction

endpackage

// File: rtl/stepper_seq_if.sv
// Move-command handshake between a host and stepper_seq.
// Ports: cmd_valid/cmd_steps/cmd_dir from master, cmd_ready from slave.
interface stepper_seq_if #(
    parameter int STEPS_W = 8
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic [STEPS_W-1:0] cmd_steps;
    logic               cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_dir,
        output cmd_ready
    );

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus rising-edge detector.
// Ports: clk, rst (async, active low), din (async), tick (1-cycle pulse).
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic tick
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign tick = s2_q & ~s3_q;

endmodule

// File: rtl/stepper_seq.sv
// Full-step sequencer: runs a move command, holds, then de-energizes.
// Ports: clk, rst, step_clk, cmd_if (slave), abort, coil, busy, done, steps_left.
module stepper_seq
    import stepper_pkg::*;
#(
    parameter int STEPS_W    = 8,
    parameter int HOLD_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_clk,
    stepper_seq_if.slave       cmd_if,
    input  logic               abort,
    output logic [COIL_W-1:0]  coil,
    output logic               busy,
    output logic               done,
    output logic [STEPS_W-1:0] steps_left
);

    localparam int HOLD_W =
        (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [STEPS_W-1:0] STEP_ONE = STEPS_W'(1);

    logic tick;

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic                dir_q, dir_d;
    logic [STEPS_W-1:0]  steps_q, steps_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [COIL_W-1:0]   coil_q, coil_d;
    logic                done_q, done_d;

    edge_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (step_clk),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        steps_d = steps_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    dir_d   = cmd_if.cmd_dir;
                    steps_d = cmd_if.cmd_steps;
                    if (cmd_if.cmd_steps == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // abort beats a coincident tick
                if (abort) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    idx_d   = dir_q ? idx_q + 2'd1
                                    : idx_q - 2'd1;
                    steps_d = steps_q - STEP_ONE;
                    if (steps_q == STEP_ONE) begin
                        if (HOLD_TICKS == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_HOLD;
                            hold_d  = HOLD_INIT;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    hold_d = hold_q - HOLD_ONE;
                    if (hold_q == HOLD_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // coil follows the next state so RUN is energized on entry
    always_comb begin
        coil_d = '0;
        if (state_d == ST_RUN || state_d == ST_HOLD) begin
            coil_d = phase_of(idx_d);
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            dir_q   <= 1'b0;
            steps_q <= '0;
            hold_q  <= '0;
            coil_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            steps_q <= steps_d;
            hold_q  <= hold_d;
            coil_q  <= coil_d;
            done_q  <= done_d;
        end
    end

    assign cmd_if.cmd_ready = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign coil             = coil_q;
    assign done             = done_q;
    assign steps_left       = steps_q;

endmodule

// File: tb/tb_stepper_seq.sv
// Self-checking bench for stepper_seq.
// Table vectors, hand sequences and random moves vs a position model.
module tb_stepper_seq;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       step_clk = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_steps = '0;
    logic       cmd_dir = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] coil;
    logic       busy;
    logic       done;
    logic [7:0] steps_left;
    logic       cmd_ready;

    bit gen_en = 1'b0;
    bit rise = 1'b0;
    bit sc_prev = 1'b1;
    int checks = 0;
    int failures = 0;
    int model_idx = 0;

    typedef struct {
        int         steps;
        bit         dir;
        logic [3:0] first_c;
        logic [3:0] last_c;
    } vec_t;

    vec_t vecs[5];

    stepper_seq_if #(.STEPS_W(8)) bus ();

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_steps = cmd_steps;
    assign bus.cmd_dir   = cmd_dir;
    assign cmd_ready     = bus.cmd_ready;

    stepper_seq #(
        .STEPS_W    (8),
        .HOLD_TICKS (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_clk   (step_clk),
        .cmd_if     (bus),
        .abort      (abort),
        .coil       (coil),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (gen_en) begin
                cnt++;
                if (cnt == 10) begin
                    step_clk = ~step_clk;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    function automatic int wrap4(input int x);
        return ((x % 4) + 4) % 4;
    endfunction

    // full-step pattern: 1100 rotated right by the index
    function automatic logic [3:0] ph(input int i);
        logic [7:0] t;
        t = 8'b1100_1100 >> wrap4(i);
        return t[3:0];
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        rise = step_clk && !sc_prev;
        sc_prev = step_clk;
    endtask

    task automatic wait_ready();
        bit got;
        got = 0;
        for (int k = 0; k < 400; k++) begin
            if (cmd_ready) begin
                got = 1;
                break;
            end
            cyc();
        end
        if (!got) chk("ready_wait", 0, 1);
    endtask

    task automatic wait_done(input string nm);
        bit got;
        got = 0;
        for (int k = 0; k < 4000; k++) begin
            cyc();
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) chk(nm, 0, 1);
    endtask

    task automatic run_cmd(input int n, input bit d,
                           output logic [3:0] fc,
                           output logic [3:0] lc);
        logic [3:0] prev;
        logic [3:0] seen[$];
        int edges;
        bit got;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_steps = n[7:0];
        cmd_dir   = d;
        cyc();
        cmd_valid = 1'b0;
        chk("acc_busy", busy, 1);
        fc = coil;
        lc = coil;
        if (n == 0) begin
            chk("zero_coil", coil, 0);
            chk("zero_done", done, 1);
            chk("zero_sl", steps_left, 0);
            cyc();
            chk("zero_busy_end", busy, 0);
            chk("zero_done_end", done, 0);
            return;
        end
        chk("acc_coil", coil, ph(model_idx));
        chk("acc_sl", steps_left, n);
        prev = coil;
        edges = 0;
        got = 0;
        for (int k = 0; k < 4000; k++) begin
            cyc();
            if (rise) edges++;
            if (done) begin
                got = 1;
                break;
            end
            if (coil !== prev) begin
                seen.push_back(coil);
                prev = coil;
                edges = 0;
            end
        end
        if (!got) chk("done_wait", 0, 1);
        chk("done_coil", coil, 0);
        chk("done_sl", steps_left, 0);
        chk("n_steps", seen.size(), n);
        for (int i = 0; i < seen.size() && i < n; i++) begin
            chk("step_coil", seen[i],
                ph(model_idx + (d ? i + 1 : -(i + 1))));
        end
        chk("hold_ticks", edges, HOLD);
        lc = prev;
        cyc();
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        model_idx = wrap4(model_idx + (d ? n : -n));
    endtask

    initial begin
        logic [3:0] fc, lc;
        bit got;

        vecs[0] = '{5, 1'b1, 4'b1100, 4'b0110};
        vecs[1] = '{2, 1'b0, 4'b0110, 4'b1001};
        vecs[2] = '{0, 1'b1, 4'b0000, 4'b0000};
        vecs[3] = '{1, 1'b1, 4'b1001, 4'b1100};
        vecs[4] = '{3, 1'b0, 4'b1100, 4'b0110};

        // reset with step_clk high
        repeat (3) cyc();
        chk("rst_coil", coil, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sl", steps_left, 0);
        rst = 1'b1;
        repeat (8) cyc();
        chk("rel_coil", coil, 0);
        chk("rel_busy", busy, 0);
        gen_en = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_cmd(vecs[v].steps, vecs[v].dir, fc, lc);
            chk("vec_first", fc, vecs[v].first_c);
            chk("vec_last", lc, vecs[v].last_c);
        end

        // abort ignored while idle
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);

        // abort coincident with the 3rd tick
        wait_ready();
        cmd_valid = 1'b1;
        cmd_steps = 8'd10;
        cmd_dir   = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        chk("ab_coil0", coil, ph(model_idx));
        got = 0;
        for (int k = 0; k < 600; k++) begin
            cyc();
            if (steps_left == 8'd8) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("ab_wait8", 0, 1);
        chk("ab_coil2", coil, ph(model_idx + 2));
        got = 0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (rise) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("ab_rise", 0, 1);
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("ab_done", done, 1);
        chk("ab_coil", coil, 0);
        chk("ab_sl", steps_left, 8);
        cyc();
        chk("ab_done_end", done, 0);
        chk("ab_busy_end", busy, 0);
        model_idx = wrap4(model_idx + 2);
        run_cmd(1, 1'b0, fc, lc);

        // reset during HOLD
        wait_ready();
        cmd_valid = 1'b1;
        cmd_steps = 8'd1;
        cmd_dir   = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 200; k++) begin
            cyc();
            if (busy && steps_left == 8'd0) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("hold_wait", 0, 1);
        repeat (3) cyc();
        chk("hold_coil", coil, ph(model_idx + 1));
        rst = 1'b0;
        #1;
        chk("mrst_coil", coil, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        cyc();
        chk("mrst_done2", done, 0);
        rst = 1'b1;
        model_idx = 0;

        // command held valid across a move
        cmd_valid = 1'b1;
        cmd_steps = 8'd1;
        cmd_dir   = 1'b1;
        wait_done("q_done1");
        chk("q_coil_done", coil, 0);
        cyc();
        chk("q_gap_busy", busy, 0);
        chk("q_gap_ready", cmd_ready, 1);
        cyc();
        chk("q_acc_busy", busy, 1);
        chk("q_acc_coil", coil, ph(1));
        cmd_valid = 1'b0;
        wait_done("q_done2");
        cyc();
        model_idx = 2;

        // random moves against the position model
        for (int r = 0; r < 6; r++) begin
            int n;
            bit d;
            n = int'($urandom_range(0, 6));
            d = bit'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) cyc();
            run_cmd(n, d, fc, lc);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
